payload_fifo_ctrl: RTL and testbench

PAYLOAD_FIFO_CTRL -- requirements
Module: payload_fifo_ctrl

---
 rtl/payload_fifo_ctrl.sv | 167 ++++++++++++++++
 tb/tb_payload_fifo_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/payload_fifo_ctrl.sv
// payload_fifo_ctrl
//
// Controller that turns an external single-port-per-direction synchronous RAM into a
// first-word-fall-through FIFO. Pushes are written straight to RAM. Reads are prefetched
// into a 2-entry output buffer so that RD_DATA/RD_VALID come from registers. One push and
// one pop per cycle can be sustained.
//
// Parameters
//   WIDTH        payload word width in bits
//   DEPTH        RAM word count (power of two, >= 4)
//   AFULL_LEVEL  RAM occupancy at which WR_AFULL asserts
//
// Ports
//   CLOCK, RESET           single rising-edge clock, synchronous active-high reset
//   WR_EN, WR_DATA         push request and word
//   WR_FULL, WR_AFULL      RAM occupancy == DEPTH / >= AFULL_LEVEL
//   RD_VALID, RD_READY     head-word handshake; a pop is RD_VALID & RD_READY
//   RD_DATA                head word
//   COUNT                  words held: RAM + in-flight read + output buffer
//   RAM_WEN/WADDR/WDATA    RAM write port, driven combinationally from the push
//   RAM_REN/RADDR          RAM read port
//   RAM_RDATA              RAM read data, valid the cycle after RAM_REN
//   OVERFLOW, UNDERFLOW    sticky error flags, present only when the macro
//                          PAYLOAD_FIFO_CTRL_ERR_FLAGS_EN is defined
module payload_fifo_ctrl #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH       = 128,
  parameter int unsigned AFULL_LEVEL = 124,
  localparam int unsigned AW         = $clog2(DEPTH)
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             WR_EN,
  input  logic [WIDTH-1:0] WR_DATA,
  output logic             WR_FULL,
  output logic             WR_AFULL,
  output logic             RD_VALID,
  input  logic             RD_READY,
  output logic [WIDTH-1:0] RD_DATA,
  output logic [AW+1:0]    COUNT,
  output logic             RAM_WEN,
  output logic [AW-1:0]    RAM_WADDR,
  output logic [WIDTH-1:0] RAM_WDATA,
  output logic             RAM_REN,
  output logic [AW-1:0]    RAM_RADDR,
  input  logic [WIDTH-1:0] RAM_RDATA
`ifdef PAYLOAD_FIFO_CTRL_ERR_FLAGS_EN
  ,
  output logic             OVERFLOW,
  output logic             UNDERFLOW
`endif
);

  localparam logic [AW:0] OccFull  = (AW+1)'(DEPTH);
  localparam logic [AW:0] OccAfull = (AW+1)'(AFULL_LEVEL);

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      occ_q, occ_d;       // words resident in RAM
  logic             inflight_q, inflight_d;
  logic [1:0]       bcnt_q, bcnt_d;     // output buffer entries, head is buf0
  logic [WIDTH-1:0] buf0_q, buf0_d;
  logic [WIDTH-1:0] buf1_q, buf1_d;

  logic       full, afull, bvalid, push, pop, ren;
  logic [2:0] slots;

  always_comb begin
    full   = (occ_q == OccFull);
    afull  = (occ_q >= OccAfull);
    bvalid = (bcnt_q != 2'd0);
    push   = WR_EN & ~full & ~RESET;
    pop    = bvalid & RD_READY & ~RESET;
    // Buffer slots already spoken for; a pop this cycle frees one for the new read.
    slots  = {1'b0, bcnt_q} + {2'b00, inflight_q};
    ren    = ~RESET & (occ_q != '0) & (pop ? (slots <= 3'd2) : (slots <= 3'd1));
  end

  // Pointers and occupancy
  always_comb begin
    wptr_d     = wptr_q + AW'(push);
    rptr_d     = rptr_q + AW'(ren);
    occ_d      = occ_q + (AW+1)'(push) - (AW+1)'(ren);
    inflight_d = ren;
  end

  // Output buffer: pop shifts the head out, the returning read appends behind
  // whatever remains.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    bcnt_d = bcnt_q;
    if (pop) begin
      buf0_d = buf1_q;
      bcnt_d = bcnt_d - 2'd1;
    end
    if (inflight_q) begin
      if (bcnt_d == 2'd0) begin
        buf0_d = RAM_RDATA;
      end else begin
        buf1_d = RAM_RDATA;
      end
      bcnt_d = bcnt_d + 2'd1;
    end
  end

  // Reset also drops an in-flight read: inflight_q clears, so its data is never captured.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      bcnt_q     <= 2'd0;
      buf0_q     <= '0;
      buf1_q     <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      bcnt_q     <= bcnt_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
    end
  end

  // Outputs are forced quiet while RESET is high, before the registers have cleared.
  always_comb begin
    WR_FULL   = full & ~RESET;
    WR_AFULL  = afull & ~RESET;
    RD_VALID  = bvalid & ~RESET;
    RD_DATA   = RESET ? '0 : buf0_q;
    COUNT     = (AW+2)'(occ_q) + (AW+2)'(inflight_q) + (AW+2)'(bcnt_q);
    RAM_WEN   = push;
    RAM_WADDR = wptr_q;
    RAM_WDATA = WR_DATA;
    RAM_REN   = ren;
    RAM_RADDR = rptr_q;
  end

`ifdef PAYLOAD_FIFO_CTRL_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q | (WR_EN & full);
    underflow_d = underflow_q | (RD_READY & ~bvalid);
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_comb begin
    OVERFLOW  = overflow_q;
    UNDERFLOW = underflow_q;
  end
`endif

endmodule

// File: tb/tb_payload_fifo_ctrl.sv
// Self-checking bench for payload_fifo_ctrl with a queue-based reference model and a
// behavioural synchronous RAM.
module tb_payload_fifo_ctrl;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 128;
  localparam int unsigned AFULL = 124;
  localparam int unsigned AW    = 7;

  logic             clk = 1'b0;
  logic             rst_s;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             wr_full, wr_afull, rd_valid, rd_ready;
  logic [WIDTH-1:0] rd_data;
  logic [AW+1:0]    count;
  logic             ram_wen, ram_ren;
  logic [AW-1:0]    ram_waddr, ram_raddr;
  logic [WIDTH-1:0] ram_wdata, ram_rdata;
`ifdef PAYLOAD_FIFO_CTRL_ERR_FLAGS_EN
  logic             overflow, underflow;
`endif

  always #5 clk = ~clk;

  payload_fifo_ctrl #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .AFULL_LEVEL(AFULL)
  ) dut (
    .CLOCK    (clk),
    .RESET    (rst_s),
    .WR_EN    (wr_en),
    .WR_DATA  (wr_data),
    .WR_FULL  (wr_full),
    .WR_AFULL (wr_afull),
    .RD_VALID (rd_valid),
    .RD_READY (rd_ready),
    .RD_DATA  (rd_data),
    .COUNT    (count),
    .RAM_WEN  (ram_wen),
    .RAM_WADDR(ram_waddr),
    .RAM_WDATA(ram_wdata),
    .RAM_REN  (ram_ren),
    .RAM_RADDR(ram_raddr),
    .RAM_RDATA(ram_rdata)
`ifdef PAYLOAD_FIFO_CTRL_ERR_FLAGS_EN
    ,
    .OVERFLOW (overflow),
    .UNDERFLOW(underflow)
`endif
  );

  // Behavioural RAM, never cleared by reset.
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_wen) mem[ram_waddr] <= ram_wdata;
    if (ram_ren) ram_rdata <= mem[ram_raddr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: words in RAM, one word in flight, up to two in the output buffer.
  logic [WIDTH-1:0] m_ram[$];
  logic [WIDTH-1:0] m_ob[$];
  bit               m_fl;
  logic [WIDTH-1:0] m_flw;
  int unsigned      m_wcnt, m_rcnt;
  bit               m_clean;
  bit               m_known;
  bit               m_ovf, m_udf;

  // Called at posedge+1: drive inputs, check at mid-cycle, advance model, go to next edge+1.
  task automatic step(input bit rst, input bit wen, input logic [WIDTH-1:0] wd, input bit rdy);
    bit full, afull, rv, push, pop, ren;
    int slots;
    rst_s = rst; wr_en = wen; wr_data = wd; rd_ready = rdy;
    #4;
    full  = (m_ram.size() == DEPTH);
    afull = (m_ram.size() >= AFULL);
    rv    = (m_ob.size() != 0);
    if (rst) begin
      full = 0; afull = 0; rv = 0;
    end
    push  = wen && !full && !rst;
    pop   = rv && rdy;
    slots = int'(m_ob.size()) + int'(m_fl) - int'(pop);
    ren   = !rst && (m_ram.size() > 0) && (slots < 2);
    if (m_known) begin
      check_eq("wr_full", 64'(wr_full), 64'(full));
      check_eq("wr_afull", 64'(wr_afull), 64'(afull));
      check_eq("rd_valid", 64'(rd_valid), 64'(rv));
      check_eq("ram_wen", 64'(ram_wen), 64'(push));
      check_eq("ram_ren", 64'(ram_ren), 64'(ren));
      check_eq("count", 64'(count), 64'(m_ram.size() + int'(m_fl) + m_ob.size()));
      if (rv) check_eq("rd_data", 64'(rd_data), 64'(m_ob[0]));
      else if (m_clean || rst) check_eq("rd_data_zero", 64'(rd_data), 64'd0);
      if (push) begin
        check_eq("ram_waddr", 64'(ram_waddr), 64'(m_wcnt % DEPTH));
        check_eq("ram_wdata", 64'(ram_wdata), 64'(wd));
      end
      if (ren) check_eq("ram_raddr", 64'(ram_raddr), 64'(m_rcnt % DEPTH));
`ifdef PAYLOAD_FIFO_CTRL_ERR_FLAGS_EN
      if (!rst) begin
        check_eq("overflow", 64'(overflow), 64'(m_ovf));
        check_eq("underflow", 64'(underflow), 64'(m_udf));
      end
`endif
    end
    if (rst) begin
      m_ram.delete(); m_ob.delete();
      m_fl = 0; m_wcnt = 0; m_rcnt = 0;
      m_clean = 1; m_known = 1; m_ovf = 0; m_udf = 0;
    end else begin
      if (wen && full) m_ovf = 1;
      if (rdy && !rv) m_udf = 1;
      if (pop) void'(m_ob.pop_front());
      if (m_fl) begin
        m_ob.push_back(m_flw);
        m_clean = 0;
      end
      m_fl = ren;
      if (ren) begin
        m_flw = m_ram.pop_front();
        m_rcnt++;
      end
      if (push) begin
        m_ram.push_back(wd);
        m_wcnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, '0, rdy);
  endtask

  initial begin
    rst_s = 1; wr_en = 0; wr_data = '0; rd_ready = 0;
    m_known = 0; m_clean = 1;
    @(posedge clk);
    #1;
    step(1, 0, '0, 0);
    step(1, 0, '0, 0);

    // Latency of a single word through an empty FIFO.
    step(0, 1, 32'hA5A5_0001, 0);
    step(0, 0, '0, 0);
    check_eq("lat_valid_c2", 64'(rd_valid), 64'd0);
    step(0, 0, '0, 0);
    check_eq("lat_valid_c3", 64'(rd_valid), 64'd1);
    check_eq("lat_data_c3", 64'(rd_data), 64'hA5A5_0001);
    check_eq("lat_count_c3", 64'(count), 64'd1);
    idle(2, 1);

    // Fill with no consumer; the 131st push must be dropped.
    step(1, 0, '0, 0);
    for (int i = 0; i < 131; i++) step(0, 1, 32'h3900_0000 + 32'(i), 0);
    check_eq("fill_full", 64'(wr_full), 64'd1);
    check_eq("fill_afull", 64'(wr_afull), 64'd1);
    check_eq("fill_count", 64'(count), 64'd130);
    check_eq("fill_head", 64'(rd_data), 64'h3900_0000);
`ifdef PAYLOAD_FIFO_CTRL_ERR_FLAGS_EN
    check_eq("fill_overflow", 64'(overflow), 64'd1);
`endif
    // Drain through the almost-full threshold and on to empty.
    idle(140, 1);
    check_eq("drain_count", 64'(count), 64'd0);

    // Continuous streaming, pointers wrap several times.
    step(1, 0, '0, 0);
    for (int i = 0; i < 1000; i++) step(0, 1, 32'(i), 1);
    idle(6, 1);

    // Pushing every cycle against a consumer that accepts every other cycle.
    step(1, 0, '0, 0);
    for (int i = 0; i < 300; i++) step(0, 1, 32'h4100_0000 + 32'(i), (i % 2) == 0);
    idle(320, 1);
    check_eq("toggle_count", 64'(count), 64'd0);

    // Reset while a read is in flight.
    step(1, 0, '0, 0);
    step(0, 1, 32'h0000_5555, 0);
    step(0, 0, '0, 0);
    step(1, 0, '0, 0);
    check_eq("rst_mid_valid", 64'(rd_valid), 64'd0);
    check_eq("rst_mid_count", 64'(count), 64'd0);
    step(0, 1, 32'h0000_1234, 0);
    idle(2, 0);
    check_eq("rst_mid_valid2", 64'(rd_valid), 64'd1);
    check_eq("rst_mid_data", 64'(rd_data), 64'h0000_1234);

    // Randomised traffic with phases of varying pressure and rare resets.
    for (int i = 0; i < 4000; i++) begin
      int unsigned wprob, rprob;
      wprob = ((i / 500) % 2 == 0) ? 80 : 30;
      rprob = ((i / 500) % 2 == 0) ? 30 : 85;
      step($urandom_range(0, 399) == 0, $urandom_range(0, 99) < wprob, $urandom,
           $urandom_range(0, 99) < rprob);
    end
    idle(200, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
